fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end of the 64-bit ARM pipeline. Sits directly upstream of the decode stage.
- Holds the PC, issues in-order requests to instruction memory and buffers returned instructions with their PCs in a small queue.
- Presents one instruction per cycle to decode over a valid/ready handshake.
- On branch redirect, flushes the queue and discards any responses still in flight.

Parameters:
ADDR_W, 64, PC and address width
INSTR_W, 32, instruction width
QDEPTH, 4, queue entries; also the maximum number of in-flight requests plus queued entries
RESET_PC, 64'h0, PC value after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-low (asserted when 0)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  fetch address
imem_resp_valid  in  1  instruction returned; in order, at least 1 cycle after acceptance
imem_resp_data  in  INSTR_W  returned instruction
redirect_valid  in  1  branch redirect from execute
redirect_pc  in  ADDR_W  redirect target
id_valid  out  1  instruction available to decode
id_ready  in  1  decode accepts
id_instr  out  INSTR_W  instruction at queue head
id_pc  out  ADDR_W  PC of id_instr

Behaviour:
- Reset (reset==0, asynchronous):
  - imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0.
  - Queue empty; in-flight=0; drop=0; resp_pc=RESET_PC; state=WAIT.
- State machine:
  - WAIT: one cycle after reset release, then RUN.
  - RUN: imem_req_valid=1 when count+inflight<QDEPTH.
  - FLUSH: imem_req_valid=0 while drop>0; return to RUN when drop reaches 0.
- Request handshake:
  - A request is accepted when imem_req_valid & imem_req_ready. On acceptance, PC += 4 (mod 2^64) and inflight += 1.
  - While imem_req_ready is low, imem_req_addr and imem_req_valid stay stable.
- Response handling:
  - Each imem_resp_valid decrements inflight.
  - If drop>0, the response is discarded and drop decrements.
  - Otherwise {resp_pc, data} is enqueued and resp_pc += 4.
  - Queue overflow cannot occur because of the credit rule; an assertion checks this.
- Dequeue and latency:
  - id_valid = queue not empty. id_instr and id_pc come from the queue head. id_valid & id_ready dequeues.
  - Response-to-id_valid latency is 1 cycle (registered queue).
- Redirect (redirect_valid=1):
  - PC and resp_pc load redirect_pc; queue cleared.
  - drop = inflight after this cycle's updates, so a request accepted in the same cycle is dropped and a response in the same cycle is dropped.
  - If drop>0, state=FLUSH; else RUN, with the first new request in the next cycle.
  - A dequeue in the same cycle completes, then the flush applies.
  - A redirect arriving during FLUSH reloads PC; drop is recomputed with the same rule.
- Reset asserted mid-operation: immediate return to reset values. Responses that arrive later, before any new request, are ignored because inflight==0.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the queue is empty, a non-dropped response is driven combinationally onto id_valid/id_instr/id_pc in the same cycle. If id_ready is high it is consumed without being enqueued; otherwise it is enqueued as usual. Latency 0.
- Undefined: latency is always 1 cycle through the queue.

Decomposition:
- Package fetch_pkg: ADDR_W, INSTR_W, INSTR_BYTES=4, typedef fetch_state_t {WAIT, RUN, FLUSH}, struct fetch_entry_t {pc, instr}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, depth QDEPTH, with push/pop/clear, count, and empty/full flags. It uses the same asynchronous active-low reset.

Test Plan:
- Release reset; memory always ready, 1-cycle response, data = addr^32'hA5A5_0000 → requests 0,4,8,…; id_pc 0,4,8 in order with matching instrs; first id_valid 3 cycles after release.
- Hold id_ready=0 → after 4 requests imem_req_valid=0, 4 entries queued; raise id_ready → entries 0,4,8,C drain, then requests resume at 0x10.
- Hold imem_req_ready=0 for 5 cycles with addr 0x8 pending → addr stays 0x8, valid stays 1, PC does not advance.
- Redirect to 0x1000 with 2 requests in flight → the next 2 responses are dropped, no requests issue during FLUSH, first id_pc=0x1000.
- Assert reset mid-stream with 3 entries queued → id_valid=0 and imem_req_valid=0 immediately; after release, fetch restarts at RESET_PC.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC → second request address is 0x0; id_pc wraps identically.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state type and queue entry type for the
// instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch advances one instruction; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO of {pc, instr} entries between the
// instruction-memory response port and decode. Clear has priority over
// push/pop so a redirect empties the queue in a single cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         clear_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic         empty_o,
  output logic         full_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage, pointers and occupancy; storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // The fetch credit scheme must never push into a full queue that is not draining.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(push_i && full_o && !pop_i && !clear_i))
    else $error("fetch_queue overflow");

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end. Holds the PC, issues in-order
// requests to instruction memory while credits allow, queues returned
// instructions with their PCs and hands them to decode over valid/ready.
// A redirect reloads the PC, empties the queue and discards every response
// still in flight.
//
// Build option: define FETCH_BYPASS_EN to forward a response straight to
// decode when the queue is empty (zero-cycle latency).
//
// state | meaning
// ------+------------------------------------------------------------
// WAIT  | one idle cycle after reset release
// RUN   | fetching; request valid while queued + in-flight < QDEPTH
// FLUSH | redirect pending; no requests until stale responses drained
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned       QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc
);

  localparam int unsigned   CW      = $clog2(QDEPTH + 1);
  localparam logic [CW:0]   CREDITS = (CW + 1)'(QDEPTH);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic              req_fire;
  logic              resp_fire;
  logic              resp_keep;
  logic [CW:0]       credits_used;

  fetch_entry_t      resp_entry;
  fetch_entry_t      q_head;
  logic [CW-1:0]     q_count;
  logic              q_empty;
  logic              q_full;
  logic              q_push;
  logic              q_pop;

  // Responses arriving with nothing in flight (e.g. after reset) are ignored.
  assign req_fire     = imem_req_valid & imem_req_ready;
  assign resp_fire    = imem_resp_valid & (inflight_q != '0);
  assign resp_keep    = resp_fire & (drop_q == '0) & ~redirect_valid;
  assign credits_used = {1'b0, q_count} + {1'b0, inflight_q};

  assign imem_req_valid = (state_q == RUN) && (credits_used < CREDITS) && !q_full;
  assign imem_req_addr  = pc_q;
  assign resp_entry     = '{pc: resp_pc_q, instr: imem_resp_data};

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass   = q_empty & resp_keep;
  assign id_valid = ~q_empty | bypass;
  assign id_instr = bypass ? imem_resp_data : q_head.instr;
  assign id_pc    = bypass ? resp_pc_q : q_head.pc;
  assign q_push   = resp_keep & ~(bypass & id_ready);
  assign q_pop    = id_ready & ~q_empty;
`else
  assign id_valid = ~q_empty;
  assign id_instr = q_head.instr;
  assign id_pc    = q_head.pc;
  assign q_push   = resp_keep;
  assign q_pop    = id_ready & ~q_empty;
`endif

  // Next PC / response PC / credit counters; a redirect overrides after normal updates.
  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);
    if (req_fire) begin
      pc_d = next_pc(pc_q);
    end
    if (resp_fire && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
    if (resp_keep) begin
      resp_pc_d = next_pc(resp_pc_q);
    end
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
      drop_d    = inflight_d;
    end
  end

  // Fetch FSM and its counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WAIT;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      if (redirect_valid) begin
        state_q <= (inflight_d != '0) ? FLUSH : RUN;
      end else begin
        unique case (state_q)
          WAIT:    state_q <= RUN;
          RUN:     state_q <= RUN;
          FLUSH:   state_q <= (drop_d == '0) ? RUN : FLUSH;
          default: state_q <= WAIT;
        endcase
      end
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (q_push),
    .entry_i (resp_entry),
    .pop_i   (q_pop),
    .clear_i (redirect_valid),
    .head_o  (q_head),
    .count_o (q_count),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. A transaction-level model
// (queues of fetched PCs/instructions, credit counts) predicts every output
// each cycle; literal expectations pin the model for the key scenarios.
// A second instance with RESET_PC = 0xFFFF_FFFF_FFFF_FFFC checks PC wrap.
module tb_fetch_stage;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int          QD      = 4;
  localparam logic [31:0] XOR_K   = 32'hA5A5_0000;

  typedef struct packed { logic [63:0] pc; logic [31:0] instr; } ment_t;
  typedef struct { logic [63:0] addr; int due; } pend_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_ready, id_ready, redirect_valid;
  logic [63:0] redirect_pc;
  logic        rv0, rv1, rsv0, rsv1, idv0, idv1;
  logic [63:0] addr0, addr1, idp0, idp1;
  logic [31:0] rsd0, rsd1, idi0, idi1;

  fetch_stage #(.QDEPTH(QD), .RESET_PC(64'h0)) dut0 (
    .clk(clk), .reset(reset),
    .imem_req_valid(rv0), .imem_req_ready(mem_ready), .imem_req_addr(addr0),
    .imem_resp_valid(rsv0), .imem_resp_data(rsd0),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(idv0), .id_ready(id_ready), .id_instr(idi0), .id_pc(idp0));

  fetch_stage #(.QDEPTH(QD), .RESET_PC(WRAP_PC)) dut1 (
    .clk(clk), .reset(reset),
    .imem_req_valid(rv1), .imem_req_ready(mem_ready), .imem_req_addr(addr1),
    .imem_resp_valid(rsv1), .imem_resp_data(rsd1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(idv1), .id_ready(id_ready), .id_instr(idi1), .id_pc(idp1));

  int checks = 0;
  int errors = 0;

  // model of dut0
  logic [63:0] m_pc, m_rpc;
  int          m_infl, m_drop;
  bit          m_started;
  ment_t       m_q[$];

  // observation logs and memory responder state
  logic [63:0] acc0[$], acc1[$], dpc0[$], dpc1[$];
  logic [31:0] din0[$], din1[$];
  pend_t       pend0[$], pend1[$];
  int          cyc, lat, rv_count, since_rel, first_idv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    acc0.delete(); acc1.delete(); dpc0.delete(); dpc1.delete();
    din0.delete(); din1.delete(); rv_count = 0;
  endtask

  // Compare outputs with the model, advance the model, step one clock, drive memory responses.
  task automatic cycle();
    bit    exp_rv;
    ment_t e;
    pend_t p;
    #1;
    if (!reset) begin
      chk("rst_req_valid", rv0, 0);
      chk("rst_req_addr", addr0, 64'h0);
      chk("rst_req_addr_wrap", addr1, WRAP_PC);
      chk("rst_id_valid", idv0, 0);
      chk("rst_id_instr", idi0, 0);
      chk("rst_id_pc", idp0, 0);
      m_started = 0; m_pc = '0; m_rpc = '0; m_infl = 0; m_drop = 0; m_q.delete();
      since_rel = 0; first_idv = -1;
    end else begin
      exp_rv = m_started && (m_drop == 0) && (m_q.size() + m_infl < QD);
      chk("req_valid", rv0, exp_rv);
      if (exp_rv) chk("req_addr", addr0, m_pc);
      chk("id_valid", idv0, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("id_pc", idp0, m_q[0].pc);
        chk("id_instr", idi0, m_q[0].instr);
      end
      if (idv0 && first_idv < 0) first_idv = since_rel;
      if (idv0 && id_ready) begin dpc0.push_back(idp0); din0.push_back(idi0); end
      if (idv1 && id_ready) begin dpc1.push_back(idp1); din1.push_back(idi1); end
      if (rv0 && mem_ready) acc0.push_back(addr0);
      if (rv1 && mem_ready) acc1.push_back(addr1);
      if (rv0) rv_count++;
      if (m_q.size() != 0 && id_ready) e = m_q.pop_front();
      if (rsv0 && m_infl > 0) begin
        m_infl--;
        if (m_drop > 0) m_drop--;
        else begin
          m_q.push_back('{pc: m_rpc, instr: rsd0});
          m_rpc = m_rpc + 64'd4;
        end
      end
      if (exp_rv && mem_ready) begin m_pc = m_pc + 64'd4; m_infl++; end
      if (redirect_valid) begin
        m_pc = redirect_pc; m_rpc = redirect_pc; m_q.delete(); m_drop = m_infl;
      end
      m_started = 1;
      if (rv0 && mem_ready) pend0.push_back('{addr0, cyc + lat});
      if (rv1 && mem_ready) pend1.push_back('{addr1, cyc + lat});
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (reset) since_rel++;
    rsv0 = 1'b0; rsd0 = '0; rsv1 = 1'b0; rsd1 = '0;
    if (pend0.size() > 0 && pend0[0].due <= cyc) begin
      p = pend0.pop_front(); rsv0 = 1'b1; rsd0 = p.addr[31:0] ^ XOR_K;
    end
    if (pend1.size() > 0 && pend1[0].due <= cyc) begin
      p = pend1.pop_front(); rsv1 = 1'b1; rsd1 = p.addr[31:0] ^ XOR_K;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    redirect_valid = 1'b0;
    repeat (n) cycle();
    reset = 1'b1;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; mem_ready = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; rsv0 = 1'b0; rsv1 = 1'b0; rsd0 = '0; rsd1 = '0;
    lat = 1; cyc = 0; since_rel = 0; first_idv = -1; rv_count = 0;
    m_started = 0; m_pc = '0; m_rpc = '0; m_infl = 0; m_drop = 0;
    @(negedge clk);

    // 1: streaming fetch, 1-cycle memory, plus wrap on the second instance
    do_reset(3);
    repeat (12) cycle();
    chk("t1_first_id_valid_latency", first_idv, 3);
    chk("t1_ndeq0", dpc0.size() >= 3, 1);
    if (dpc0.size() >= 3) begin
      chk("t1_pc0", dpc0[0], 64'h0);
      chk("t1_pc1", dpc0[1], 64'h4);
      chk("t1_pc2", dpc0[2], 64'h8);
      chk("t1_instr0", din0[0], 32'hA5A5_0000);
      chk("t1_instr2", din0[2], 32'hA5A5_0008);
    end
    chk("t1_nacc1", acc1.size() >= 2, 1);
    if (acc1.size() >= 2) begin
      chk("t1_wrap_req0", acc1[0], WRAP_PC);
      chk("t1_wrap_req1", acc1[1], 64'h0);
    end
    chk("t1_ndeq1", dpc1.size() >= 2, 1);
    if (dpc1.size() >= 2) begin
      chk("t1_wrap_pc0", dpc1[0], WRAP_PC);
      chk("t1_wrap_pc1", dpc1[1], 64'h0);
      chk("t1_wrap_instr0", din1[0], 32'h5A5A_FFFC);
    end

    // 2: decode stalled, queue fills, then drains and fetch resumes
    id_ready = 1'b0;
    do_reset(3);
    repeat (10) cycle();
    chk("t2_req_valid_stalled", rv0, 0);
    chk("t2_accepted", acc0.size(), 4);
    chk("t2_id_valid", idv0, 1);
    id_ready = 1'b1;
    clear_logs();
    repeat (10) cycle();
    chk("t2_ndeq", dpc0.size() >= 4, 1);
    if (dpc0.size() >= 4) begin
      chk("t2_pc0", dpc0[0], 64'h0);
      chk("t2_pc1", dpc0[1], 64'h4);
      chk("t2_pc2", dpc0[2], 64'h8);
      chk("t2_pc3", dpc0[3], 64'hC);
    end
    chk("t2_nacc", acc0.size() >= 1, 1);
    if (acc0.size() >= 1) chk("t2_resume_addr", acc0[0], 64'h10);

    // 3: memory back-pressure holds the request stable
    do_reset(3);
    n = 0;
    while (!(rv0 === 1'b1 && addr0 === 64'h8) && n < 20) begin cycle(); n++; end
    chk("t3_reach_addr8", n < 20, 1);
    mem_ready = 1'b0;
    repeat (5) begin
      cycle();
      chk("t3_hold_valid", rv0, 1);
      chk("t3_hold_addr", addr0, 64'h8);
    end
    mem_ready = 1'b1;
    clear_logs();
    repeat (4) cycle();
    chk("t3_nacc", acc0.size() >= 2, 1);
    if (acc0.size() >= 2) begin
      chk("t3_acc0", acc0[0], 64'h8);
      chk("t3_acc1", acc0[1], 64'hC);
    end

    // 4: redirect with two requests in flight (3-cycle memory)
    lat = 3;
    do_reset(4);
    n = 0;
    while (m_infl != 2 && n < 20) begin cycle(); n++; end
    chk("t4_two_inflight", n < 20, 1);
    mem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h1000;
    cycle();
    redirect_valid = 1'b0;
    mem_ready = 1'b1;
    clear_logs();
    repeat (2) cycle();
    chk("t4_no_req_in_flush", rv_count, 0);
    repeat (12) cycle();
    chk("t4_nacc", acc0.size() >= 1, 1);
    if (acc0.size() >= 1) chk("t4_first_req", acc0[0], 64'h1000);
    chk("t4_ndeq", dpc0.size() >= 1, 1);
    if (dpc0.size() >= 1) begin
      chk("t4_first_id_pc", dpc0[0], 64'h1000);
      chk("t4_first_id_instr", din0[0], 32'hA5A5_1000);
    end

    // 5: reset asserted mid-stream with three entries queued
    lat = 1;
    id_ready = 1'b0;
    do_reset(4);
    n = 0;
    while (m_q.size() != 3 && n < 30) begin cycle(); n++; end
    chk("t5_three_queued", n < 30, 1);
    chk("t5_pre_id_valid", idv0, 1);
    reset = 1'b0;
    #1;
    chk("t5_async_id_valid", idv0, 0);
    chk("t5_async_req_valid", rv0, 0);
    repeat (3) cycle();
    reset = 1'b1;
    rsv0 = 1'b1;
    rsd0 = 32'hDEAD_BEEF;
    id_ready = 1'b1;
    clear_logs();
    repeat (12) cycle();
    chk("t5_nacc", acc0.size() >= 1, 1);
    if (acc0.size() >= 1) chk("t5_restart_addr", acc0[0], 64'h0);
    chk("t5_ndeq", dpc0.size() >= 1, 1);
    if (dpc0.size() >= 1) begin
      chk("t5_first_id_pc", dpc0[0], 64'h0);
      chk("t5_first_id_instr", din0[0], 32'hA5A5_0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
